bcd_entry_accumulator: RTL and testbench
========================================

Name: bcd_entry_accumulator

Overview:
- Parametrised successor to the 3-digit DIP-switch number capture block.
- Collects NUM_DIGITS BCD digits, most significant first, from a 4-bit switch bank. Each digit is captured on a rising edge of `enter`.
- Digits above 9 are rejected. `clear` aborts entry.
- The block converts the digits to binary sequentially, one multiply-accumulate per cycle, and presents the result on a valid/ready handshake to the downstream adder datapath.

Parameters:
- NUM_DIGITS, default 3: number of BCD digits per operand. Range 1..6.
- OUT_W, default 12: width of number_out. Elaboration fails unless 2^OUT_W > 10^NUM_DIGITS - 1.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- digit_in  input  4  BCD digit from switches. Synchronous to clk.
- enter  input  1  capture request, level. The block detects the rising edge internally. Already debounced and synchronised.
- clear  input  1  synchronous abort/restart, level.
- out_ready  input  1  downstream accepts number_out.
- number_out  output  OUT_W  binary value of the entered digits.
- out_valid  output  1  number_out holds a complete, converted operand.
- digit_count  output  $clog2(NUM_DIGITS+1)  digits captured so far in the current entry.
- digit_err  output  1  single-cycle pulse: rejected digit.

Behaviour:
- Reset values: number_out=0, out_valid=0, digit_count=0, digit_err=0, state=ENTRY, accumulator=0, conversion index=0, enter_q=1.
  - enter_q resets to 1, so an enter held high through reset release is not treated as an edge.
- Edge detect: enter_edge = enter & ~enter_q. enter_q registers enter every cycle in every state.
- ENTRY state, on enter_edge:
  - digit_in <= 9: store the digit in slot digit_count, then increment digit_count.
  - digit_in > 9: digit_err=1 for exactly one cycle. No store, and digit_count is unchanged.
- ENTRY -> CONVERT: on the edge that stores digit NUM_DIGITS. That same edge clears the accumulator and the index.
- CONVERT state:
  - Each cycle: acc <= acc*10 + digit[idx], then idx++. acc*10 is computed as (acc<<3)+(acc<<1), truncated to OUT_W, which cannot overflow given the parameter check.
  - Lasts exactly NUM_DIGITS cycles. On the final step: number_out <= result, out_valid <= 1, state -> HOLD.
- Latency: the edge capturing the last digit is edge k. out_valid is first high after edge k+NUM_DIGITS, i.e. 3 cycles for the default.
- HOLD state:
  - number_out and out_valid stay stable while out_ready=0, for any duration.
  - On the cycle where out_valid & out_ready: out_valid <= 0, digit_count <= 0, state -> ENTRY.
- enter_edge in CONVERT or HOLD: ignored, with no error. The edge is consumed and not queued.
- clear, in any state, has priority over everything else. Next cycle: digit_count=0, idx=0, acc=0, out_valid=0, state=ENTRY.
  - number_out retains its last value.
  - digit_err is not asserted.
  - clear is the only path by which out_valid drops without a handshake.
- clear and enter_edge in the same cycle: clear wins and the digit is discarded.
- out_valid is never combinationally dependent on out_ready.
- number_out changes only on the CONVERT -> HOLD step.
- Reset mid-conversion or in HOLD: all state returns to reset values immediately (asynchronous). No partial result appears.

Decomposition:
- Package bcd_entry_pkg:
  - state enum {ENTRY, CONVERT, HOLD} (2-bit).
  - DIGIT_W=4, MAX_BCD=4'd9.
  - A function computing the minimum output width for a given digit count, used by the elaboration check.
- One sub-module, bcd_mac_step: combinational acc*10+digit. Parameter OUT_W. Reused by later multi-operand blocks.

Test Plan:
- Enter edges with digits 1, 2, 3, out_ready=1 -> out_valid high 3 cycles after the third edge, number_out=123, pulse lasts 1 cycle, digit_count returns to 0.
- Digits 9, 9, 9 with out_ready=0 for 5 cycles -> number_out=999 and out_valid held stable all 5 cycles. Handshake in cycle 6, then out_valid=0.
- Digit 4'hC on an enter edge while digit_count=1 -> digit_err pulses 1 cycle, digit_count stays 1. Subsequent digits 5, 7 (after a first digit of 2) -> 257.
- Digits 4, 5, then clear, then 0, 0, 8 -> digit_count drops to 0 after clear, final number_out=8. Also: enter held high across reset release produces no capture.
- Async reset asserted on the 2nd CONVERT cycle of 6, 6, 6 -> out_valid never rises, all outputs return to 0. A fresh 1, 0, 0 -> 100.
- NUM_DIGITS=4, OUT_W=14, digits 9, 8, 7, 6 -> 9876 after 4 conversion cycles. Enter edges during CONVERT/HOLD are ignored.

Source files
------------

// File: rtl/bcd_entry_pkg.sv
// Shared types and constants for the BCD entry / conversion blocks.
// Also holds the output-width helper used by the elaboration-time parameter check.
package bcd_entry_pkg;

    typedef enum logic [1:0] {
        ENTRY   = 2'd0,
        CONVERT = 2'd1,
        HOLD    = 2'd2
    } state_e;

    localparam int         DIGIT_W = 4;
    localparam logic [3:0] MAX_BCD = 4'd9;

    // Smallest w with 2^w > 10^num_digits - 1.
    function automatic int min_out_w(input int num_digits);
        longint max_val;
        int     w;
        max_val = 1;
        for (int i = 0; i < num_digits; i++) max_val = max_val * 10;
        max_val = max_val - 1;
        w = 1;
        for (int b = 0; b < 62; b++) begin
            if ((longint'(1) << w) <= max_val) w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/bcd_mac_step.sv
// One decimal multiply-accumulate step: acc*10 + digit, truncated to OUT_W.
// Pure combinational; the caller guarantees the result fits.
module bcd_mac_step
    import bcd_entry_pkg::*;
#(
    parameter int OUT_W = 12
) (
    input  logic [OUT_W-1:0]   acc_in,
    input  logic [DIGIT_W-1:0] digit,
    output logic [OUT_W-1:0]   acc_out
);

    // x*10 as x*8 + x*2 keeps this a pair of shifts and adds.
    assign acc_out = (acc_in << 3) + (acc_in << 1) + OUT_W'(digit);

endmodule

// File: rtl/bcd_entry_accumulator.sv
// Captures NUM_DIGITS BCD digits (MSD first) on rising edges of enter, converts them
// to binary one digit per cycle, and offers the result on a valid/ready handshake.
module bcd_entry_accumulator
    import bcd_entry_pkg::*;
#(
    parameter int NUM_DIGITS = 3,
    parameter int OUT_W      = 12
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [DIGIT_W-1:0]              digit_in,
    input  logic                            enter,
    input  logic                            clear,
    input  logic                            out_ready,
    output logic [OUT_W-1:0]                number_out,
    output logic                            out_valid,
    output logic [$clog2(NUM_DIGITS+1)-1:0] digit_count,
    output logic                            digit_err
);

    localparam int CNT_W = $clog2(NUM_DIGITS + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_DIGITS - 1);

    if (NUM_DIGITS < 1 || NUM_DIGITS > 6) begin : g_bad_digits
        $error("bcd_entry_accumulator: NUM_DIGITS must be 1..6");
    end
    if (OUT_W < min_out_w(NUM_DIGITS)) begin : g_bad_width
        $error("bcd_entry_accumulator: OUT_W too narrow for NUM_DIGITS");
    end

    state_e                                state_q, state_d;
    logic [CNT_W-1:0]                      digit_count_q, digit_count_d;
    logic [CNT_W-1:0]                      idx_q, idx_d;
    logic [NUM_DIGITS-1:0][DIGIT_W-1:0]    digits_q, digits_d;
    logic [OUT_W-1:0]                      acc_q, acc_d;
    logic [OUT_W-1:0]                      number_out_q, number_out_d;
    logic                                  out_valid_q, out_valid_d;
    logic                                  digit_err_q, digit_err_d;
    logic                                  enter_q, enter_d;

    logic                                  enter_edge;
    logic                                  digit_ok;
    logic [DIGIT_W-1:0]                    cur_digit;
    logic [OUT_W-1:0]                      mac_out;

    assign enter_edge = enter & ~enter_q;
    assign digit_ok   = (digit_in <= MAX_BCD);
    assign enter_d    = enter;

    always_comb begin
        cur_digit = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == CNT_W'(i)) cur_digit = digits_q[i];
        end
    end

    bcd_mac_step #(.OUT_W(OUT_W)) u_mac (
        .acc_in  (acc_q),
        .digit   (cur_digit),
        .acc_out (mac_out)
    );

    // State register. enter_q resets high so a held enter is not seen as an edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ENTRY;
            digit_count_q <= '0;
            idx_q         <= '0;
            digits_q      <= '0;
            acc_q         <= '0;
            number_out_q  <= '0;
            out_valid_q   <= 1'b0;
            digit_err_q   <= 1'b0;
            enter_q       <= 1'b1;
        end else begin
            state_q       <= state_d;
            digit_count_q <= digit_count_d;
            idx_q         <= idx_d;
            digits_q      <= digits_d;
            acc_q         <= acc_d;
            number_out_q  <= number_out_d;
            out_valid_q   <= out_valid_d;
            digit_err_q   <= digit_err_d;
            enter_q       <= enter_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = ENTRY;
        end else begin
            case (state_q)
                ENTRY:   if (enter_edge && digit_ok && digit_count_q == LAST) state_d = CONVERT;
                CONVERT: if (idx_q == LAST) state_d = HOLD;
                HOLD:    if (out_ready) state_d = ENTRY;
                default: state_d = ENTRY;
            endcase
        end
    end

    // Datapath and output registers.
    always_comb begin
        digit_count_d = digit_count_q;
        idx_d         = idx_q;
        digits_d      = digits_q;
        acc_d         = acc_q;
        number_out_d  = number_out_q;
        out_valid_d   = out_valid_q;
        digit_err_d   = 1'b0;
        if (clear) begin
            // number_out deliberately keeps its last value.
            digit_count_d = '0;
            idx_d         = '0;
            acc_d         = '0;
            out_valid_d   = 1'b0;
        end else begin
            case (state_q)
                ENTRY: begin
                    if (enter_edge) begin
                        if (digit_ok) begin
                            for (int i = 0; i < NUM_DIGITS; i++) begin
                                if (digit_count_q == CNT_W'(i)) digits_d[i] = digit_in;
                            end
                            digit_count_d = digit_count_q + 1'b1;
                            if (digit_count_q == LAST) begin
                                acc_d = '0;
                                idx_d = '0;
                            end
                        end else begin
                            digit_err_d = 1'b1;
                        end
                    end
                end
                CONVERT: begin
                    acc_d = mac_out;
                    idx_d = idx_q + 1'b1;
                    if (idx_q == LAST) begin
                        number_out_d = mac_out;
                        out_valid_d  = 1'b1;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid_d   = 1'b0;
                        digit_count_d = '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign number_out  = number_out_q;
    assign out_valid   = out_valid_q;
    assign digit_count = digit_count_q;
    assign digit_err   = digit_err_q;

endmodule

// File: tb/tb_bcd_entry_accumulator.sv
// Bench for bcd_entry_accumulator: table-driven operands, hand-written corner sequences,
// random stimulus, all shadowed by a per-cycle queue-based reference model.
module tb_bcd_entry_accumulator;

    localparam int ND = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  digit_in;
    logic        enter, clear, out_ready;
    logic [11:0] number_out;
    logic        out_valid, digit_err;
    logic [1:0]  digit_count;

    logic [3:0]  d4;
    logic        e4, clr4, r4;
    logic [13:0] number_out4;
    logic        out_valid4, digit_err4;
    logic [2:0]  digit_count4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bcd_entry_accumulator #(.NUM_DIGITS(3), .OUT_W(12)) dut (
        .clk(clk), .reset(reset), .digit_in(digit_in), .enter(enter), .clear(clear),
        .out_ready(out_ready), .number_out(number_out), .out_valid(out_valid),
        .digit_count(digit_count), .digit_err(digit_err)
    );

    bcd_entry_accumulator #(.NUM_DIGITS(4), .OUT_W(14)) dut4 (
        .clk(clk), .reset(reset), .digit_in(d4), .enter(e4), .clear(clr4),
        .out_ready(r4), .number_out(number_out4), .out_valid(out_valid4),
        .digit_count(digit_count4), .digit_err(digit_err4)
    );

    // Reference model: digits kept in a queue, conversion modelled as a countdown.
    int m_q[$];
    bit m_prev_en;
    int m_busy;
    bit m_valid;
    int m_num;
    bit m_err;

    task automatic model_reset();
        m_q.delete();
        m_prev_en = 1'b1;
        m_busy    = 0;
        m_valid   = 1'b0;
        m_num     = 0;
        m_err     = 1'b0;
    endtask

    task automatic model_update();
        bit e;
        int v;
        if (reset) begin
            model_reset();
            return;
        end
        e = enter && !m_prev_en;
        m_prev_en = enter;
        m_err = 1'b0;
        if (clear) begin
            m_q.delete();
            m_busy  = 0;
            m_valid = 1'b0;
        end else if (m_busy > 0) begin
            m_busy--;
            if (m_busy == 0) begin
                v = 0;
                foreach (m_q[i]) v = v * 10 + m_q[i];
                m_num   = v;
                m_valid = 1'b1;
            end
        end else if (m_valid) begin
            if (out_ready) begin
                m_valid = 1'b0;
                m_q.delete();
            end
        end else if (e) begin
            if (digit_in > 9) m_err = 1'b1;
            else begin
                m_q.push_back(int'(digit_in));
                if (m_q.size() == ND) m_busy = ND;
            end
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("model_valid", 32'(out_valid), 32'(m_valid));
        chk("model_number", 32'(number_out), 32'(m_num));
        chk("model_count", 32'(digit_count), 32'(m_q.size()));
        chk("model_err", 32'(digit_err), 32'(m_err));
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
    endtask

    task automatic step();
        tick();
        @(negedge clk);
        check_model();
    endtask

    task automatic press(input logic [3:0] d);
        digit_in = d;
        enter = 1'b1;
        step();
        enter = 1'b0;
        step();
    endtask

    // Wait for the result, hold it for `delay` cycles, then hand it off.
    task automatic finish_op(input int exp, input int delay);
        int n = 0;
        while (!out_valid && n < 20) begin
            step();
            n++;
        end
        chk("valid_timeout", 32'(out_valid), 32'd1);
        chk("result", 32'(number_out), 32'(exp));
        for (int i = 0; i < delay; i++) begin
            step();
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_number", 32'(number_out), 32'(exp));
        end
        out_ready = 1'b1;
        step();
        chk("after_handshake_valid", 32'(out_valid), 32'd0);
        chk("after_handshake_count", 32'(digit_count), 32'd0);
    endtask

    typedef struct {
        int              n;
        logic [5:0][3:0] d;
        int              delay;
        int              exp;
    } vec_t;

    vec_t vecs[5];

    initial begin
        vecs[0].n = 3; vecs[0].d = 24'h000321; vecs[0].delay = 0; vecs[0].exp = 123;
        vecs[1].n = 3; vecs[1].d = 24'h000999; vecs[1].delay = 5; vecs[1].exp = 999;
        vecs[2].n = 4; vecs[2].d = 24'h0075C2; vecs[2].delay = 1; vecs[2].exp = 257;
        vecs[3].n = 3; vecs[3].d = 24'h000240; vecs[3].delay = 2; vecs[3].exp = 42;
        vecs[4].n = 3; vecs[4].d = 24'h000800; vecs[4].delay = 0; vecs[4].exp = 8;

        reset = 1'b1; enter = 1'b1; clear = 1'b0; out_ready = 1'b1; digit_in = 4'd5;
        d4 = 4'd0; e4 = 1'b0; clr4 = 1'b0; r4 = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_number", 32'(number_out), 32'd0);
        chk("rst_count", 32'(digit_count), 32'd0);
        chk("rst_err", 32'(digit_err), 32'd0);

        // enter held high across reset release: no capture.
        reset = 1'b0;
        repeat (4) step();
        chk("held_enter_count", 32'(digit_count), 32'd0);
        enter = 1'b0;
        step();

        foreach (vecs[v]) begin
            out_ready = (vecs[v].delay == 0);
            for (int i = 0; i < vecs[v].n; i++) press(vecs[v].d[i]);
            finish_op(vecs[v].exp, vecs[v].delay);
        end

        // Invalid digit pulse while digit_count=1.
        out_ready = 1'b1;
        press(4'd2);
        digit_in = 4'hC; enter = 1'b1;
        step();
        chk("err_pulse", 32'(digit_err), 32'd1);
        chk("err_count", 32'(digit_count), 32'd1);
        enter = 1'b0;
        step();
        chk("err_pulse_end", 32'(digit_err), 32'd0);
        press(4'd5);
        press(4'd7);
        finish_op(257, 0);

        // Clear mid-entry, then clear colliding with an enter edge.
        press(4'd4);
        press(4'd5);
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("clear_count", 32'(digit_count), 32'd0);
        chk("clear_no_err", 32'(digit_err), 32'd0);
        digit_in = 4'd3; enter = 1'b1; clear = 1'b1;
        step();
        clear = 1'b0; enter = 1'b0;
        chk("clear_wins_count", 32'(digit_count), 32'd0);
        step();
        press(4'd0);
        press(4'd0);
        press(4'd8);
        finish_op(8, 0);

        // Async reset during the second conversion cycle of 6,6,6.
        press(4'd6);
        press(4'd6);
        digit_in = 4'd6; enter = 1'b1;
        step();
        enter = 1'b0;
        tick();
        #2 reset = 1'b1;
        model_reset();
        #1;
        chk("midconv_rst_valid", 32'(out_valid), 32'd0);
        chk("midconv_rst_number", 32'(number_out), 32'd0);
        chk("midconv_rst_count", 32'(digit_count), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (5) begin
            step();
            chk("no_partial_valid", 32'(out_valid), 32'd0);
        end
        press(4'd1);
        press(4'd0);
        press(4'd0);
        finish_op(100, 0);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            enter     = 1'($urandom_range(0, 1));
            digit_in  = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(10, 15))
                                                    : 4'($urandom_range(0, 9));
            clear     = ($urandom_range(0, 29) == 0);
            out_ready = ($urandom_range(0, 2) != 0);
            step();
        end
        enter = 1'b0; clear = 1'b1;
        step();
        clear = 1'b0;
        step();

        // Four-digit instance: 9,8,7,6 with enter edges during CONVERT and HOLD.
        r4 = 1'b0;
        begin
            logic [15:0] ds;
            ds = 16'h9876;
            for (int i = 3; i >= 0; i--) begin
                d4 = ds[i*4 +: 4]; e4 = 1'b1;
                step();
                e4 = 1'b0;
                step();
            end
        end
        d4 = 4'd1; e4 = 1'b1;
        step();
        e4 = 1'b0;
        step();
        chk("n4_not_yet_valid", 32'(out_valid4), 32'd0);
        step();
        chk("n4_valid", 32'(out_valid4), 32'd1);
        chk("n4_result", 32'(number_out4), 32'd9876);
        chk("n4_count_full", 32'(digit_count4), 32'd4);
        e4 = 1'b1;
        step();
        e4 = 1'b0;
        step();
        chk("n4_hold_valid", 32'(out_valid4), 32'd1);
        chk("n4_hold_number", 32'(number_out4), 32'd9876);
        chk("n4_hold_err", 32'(digit_err4), 32'd0);
        r4 = 1'b1;
        step();
        chk("n4_handshake_valid", 32'(out_valid4), 32'd0);
        chk("n4_handshake_count", 32'(digit_count4), 32'd0);
        step();
        chk("n4_no_queued_edge", 32'(digit_count4), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
